// File: rtl/spike_gen_bank_pkg.sv
// Shared types and default widths for the spike generator bank.
// The SPIKE_GEN_STATS_EN build option lives in spike_gen_bank.sv.
package spike_gen_bank_pkg;

  localparam int NGEN_LOG_DEF = 8;
  localparam int NPERIOD_DEF  = 16;
  localparam int NTAG_DEF     = 11;
  localparam int NCT_DEF      = 9;

  // Storage layout of one generator at the default widths.
  typedef struct packed {
    logic [NPERIOD_DEF-1:0] period;
    logic [NPERIOD_DEF-1:0] ticks;
    logic [NTAG_DEF-1:0]    tag;
  } gen_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/spike_gen_mem.sv
// Single-port generator storage: one shared address for the program write,
// the sweep update and the combinational read. Contents are not reset.
module spike_gen_mem
  import spike_gen_bank_pkg::*;
#(
  parameter int AW = NGEN_LOG_DEF,
  parameter int W  = $bits(gen_entry_t)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/spike_gen_bank.sv
// Bank of 2**NGEN_LOG periodic spike generators swept once per time unit.
// Define SPIKE_GEN_STATS_EN to build the accepted-output counter on emitted_count.
module spike_gen_bank
  import spike_gen_bank_pkg::*;
#(
  parameter int NGEN_LOG = NGEN_LOG_DEF,
  parameter int NPERIOD  = NPERIOD_DEF,
  parameter int NTAG     = NTAG_DEF,
  parameter int NCT      = NCT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     time_unit_pulse,
  input  logic [NGEN_LOG-1:0]      gens_used,
  input  logic [(1<<NGEN_LOG)-1:0] gens_en,
  input  logic [NGEN_LOG-1:0]      prog_gen_idx,
  input  logic [NPERIOD-1:0]       prog_period,
  input  logic [NPERIOD-1:0]       prog_ticks,
  input  logic [NTAG-1:0]          prog_tag,
  input  logic                     prog_v,
  output logic                     prog_a,
  output logic [NTAG-1:0]          out_tag,
  output logic [NCT-1:0]           out_ct,
  output logic                     out_v,
  input  logic                     out_a,
  output logic                     missed_tick,
  output logic [31:0]              emitted_count
);

  typedef struct packed {
    logic [NPERIOD-1:0] period;
    logic [NPERIOD-1:0] ticks;
    logic [NTAG-1:0]    tag;
  } entry_t;

  localparam logic [NPERIOD-1:0]  P_ONE   = 1;
  localparam logic [NGEN_LOG-1:0] IDX_ONE = 1;
  localparam logic [NCT-1:0]      CT_ONE  = 1;

  state_t               r_state;
  logic [NGEN_LOG-1:0]  r_idx;
  logic                 r_pending;
  logic                 r_missed;
  logic                 r_out_v;
  logic [NTAG-1:0]      r_out_tag;
  logic [NCT-1:0]       r_out_ct;

  logic                 w_idle;
  logic                 w_prog_fire;
  logic                 w_active;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_we;
  logic [NGEN_LOG-1:0]  w_addr;
  entry_t               w_rd;
  entry_t               w_wr;

  assign w_idle      = (r_state == IDLE);
  assign prog_a      = w_idle && !r_pending;
  assign w_prog_fire = prog_v && prog_a;
  assign w_addr      = w_idle ? prog_gen_idx : r_idx;
  assign w_active    = (r_state == SWEEP) && (w_rd.period != '0) && gens_en[r_idx];
  assign w_fire      = w_active && (w_rd.ticks == '0);
  // Top index always ends the sweep, so a lowered gens_used can never wrap to 0.
  assign w_last      = (r_idx == gens_used) || (&r_idx);

  always_comb begin
    w_we = 1'b0;
    w_wr = w_rd;
    if (w_idle) begin
      w_we        = w_prog_fire;
      w_wr.period = prog_period;
      w_wr.ticks  = prog_ticks;
      w_wr.tag    = prog_tag;
    end else if (w_active) begin
      w_we       = 1'b1;
      w_wr.ticks = w_fire ? (w_rd.period - P_ONE) : (w_rd.ticks - P_ONE);
    end
  end

  spike_gen_mem #(.AW(NGEN_LOG), .W($bits(entry_t))) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wr),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_missed  <= 1'b0;
      r_out_v   <= 1'b0;
      r_out_tag <= '0;
      r_out_ct  <= '0;
    end else begin
      if (!w_idle && time_unit_pulse) begin
        r_pending <= 1'b1;
        if (r_pending) r_missed <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (time_unit_pulse || r_pending) begin
            r_state   <= SWEEP;
            r_idx     <= '0;
            // A fresh pulse landing while a pending one is consumed is kept.
            r_pending <= r_pending && time_unit_pulse;
          end
        end
        SWEEP: begin
          if (w_fire) begin
            r_out_v   <= 1'b1;
            r_out_tag <= w_rd.tag;
            r_out_ct  <= CT_ONE;
            r_state   <= EMIT;
          end else if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        EMIT: begin
          if (out_a) begin
            r_out_v <= 1'b0;
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_state <= SWEEP;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_v       = r_out_v;
  assign out_tag     = r_out_tag;
  assign out_ct      = r_out_ct;
  assign missed_tick = r_missed;

`ifdef SPIKE_GEN_STATS_EN
  logic [31:0] r_emit_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_emit_cnt <= '0;
    else if (r_out_v && out_a) r_emit_cnt <= r_emit_cnt + 32'd1;
  end

  assign emitted_count = r_emit_cnt;
`else
  assign emitted_count = 32'd0;
`endif

endmodule

// File: tb/tb_spike_gen_bank.sv
// Directed, table-driven bench for spike_gen_bank.
module tb_spike_gen_bank;

  localparam int NGEN_LOG = 8;
  localparam int NPERIOD  = 16;
  localparam int NTAG     = 11;
  localparam int NCT      = 9;
  localparam int NGEN     = 1 << NGEN_LOG;
`ifdef SPIKE_GEN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                time_unit_pulse = 1'b0;
  logic [NGEN_LOG-1:0] gens_used = '0;
  logic [NGEN-1:0]     gens_en = '0;
  logic [NGEN_LOG-1:0] prog_gen_idx = '0;
  logic [NPERIOD-1:0]  prog_period = '0;
  logic [NPERIOD-1:0]  prog_ticks = '0;
  logic [NTAG-1:0]     prog_tag = '0;
  logic                prog_v = 1'b0;
  logic                prog_a;
  logic [NTAG-1:0]     out_tag;
  logic [NCT-1:0]      out_ct;
  logic                out_v;
  logic                out_a = 1'b1;
  logic                missed_tick;
  logic [31:0]         emitted_count;

  spike_gen_bank dut (
    .clk(clk), .reset(reset), .time_unit_pulse(time_unit_pulse),
    .gens_used(gens_used), .gens_en(gens_en), .prog_gen_idx(prog_gen_idx),
    .prog_period(prog_period), .prog_ticks(prog_ticks), .prog_tag(prog_tag),
    .prog_v(prog_v), .prog_a(prog_a), .out_tag(out_tag), .out_ct(out_ct),
    .out_v(out_v), .out_a(out_a), .missed_tick(missed_tick),
    .emitted_count(emitted_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int prog_acc = 0;
  logic [NTAG-1:0] got_tag[$];
  logic [NCT-1:0]  got_ct[$];

  always @(posedge clk) begin
    if (reset) begin
      xfer_cnt = 0;
    end else begin
      if (out_v && out_a) begin
        got_tag.push_back(out_tag);
        got_ct.push_back(out_ct);
        xfer_cnt = xfer_cnt + 1;
      end
      if (prog_v && prog_a) prog_acc = prog_acc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    time_unit_pulse = 1'b0;
    prog_v = 1'b0;
    tick(2);
    reset = 1'b0;
    got_tag.delete();
    got_ct.delete();
  endtask

  task automatic prog(input logic [NGEN_LOG-1:0] idx, input logic [NPERIOD-1:0] per,
                      input logic [NPERIOD-1:0] tk, input logic [NTAG-1:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    prog_gen_idx = idx;
    prog_period  = per;
    prog_ticks   = tk;
    prog_tag     = tag;
    prog_v       = 1'b1;
    while (!prog_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("prog_accept", {63'd0, prog_a}, 64'd1);
    @(negedge clk);
    prog_v = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    time_unit_pulse = 1'b1;
    @(negedge clk);
    time_unit_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (!prog_a && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_reached", {63'd0, prog_a}, 64'd1);
  endtask

  typedef struct {
    int              exp_n;
    logic [NTAG-1:0] exp_tag;
    int              exp_cyc;
  } t1_vec_t;

  t1_vec_t         t1[7];
  logic [NTAG-1:0] t2_tags[4];
  logic [NTAG-1:0] t5_a[4];
  logic [NTAG-1:0] t5_b[3];

  initial begin
    int cyc;
    int stable;
    int p0;

    for (int i = 0; i < 7; i++) t1[i] = '{exp_n: 0, exp_tag: 11'h000, exp_cyc: 1};
    t1[0] = '{exp_n: 1, exp_tag: 11'h055, exp_cyc: 2};
    t1[3] = '{exp_n: 1, exp_tag: 11'h055, exp_cyc: 2};
    t1[6] = '{exp_n: 1, exp_tag: 11'h055, exp_cyc: 2};
    for (int i = 0; i < 4; i++) t2_tags[i] = 11'h010 + NTAG'(i);
    t5_a = '{11'h010, 11'h021, 11'h012, 11'h013};
    t5_b = '{11'h010, 11'h012, 11'h013};

    do_reset();
    check("rst_out_v", {63'd0, out_v}, 64'd0);
    check("rst_out_tag", {53'd0, out_tag}, 64'd0);
    check("rst_out_ct", {55'd0, out_ct}, 64'd0);
    check("rst_missed", {63'd0, missed_tick}, 64'd0);
    check("rst_emitted", {32'd0, emitted_count}, 64'd0);
    check("rst_prog_a", {63'd0, prog_a}, 64'd1);

    // Scenario 1: single generator, period 3
    prog(8'd0, 16'd3, 16'd0, 11'h055);
    gens_en = '0;
    gens_en[0] = 1'b1;
    gens_used = 8'd0;
    out_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      got_tag.delete();
      got_ct.delete();
      pulse();
      wait_idle(50, cyc);
      check($sformatf("t1_n_p%0d", i + 1), 64'(got_tag.size()), 64'(t1[i].exp_n));
      check($sformatf("t1_cyc_p%0d", i + 1), 64'(cyc), 64'(t1[i].exp_cyc));
      if (t1[i].exp_n == 1 && got_tag.size() == 1) begin
        check($sformatf("t1_tag_p%0d", i + 1), {53'd0, got_tag[0]}, {53'd0, t1[i].exp_tag});
        check($sformatf("t1_ct_p%0d", i + 1), {55'd0, got_ct[0]}, 64'd1);
      end
    end
    check("t1_emitted", {32'd0, emitted_count}, 64'(STATS ? xfer_cnt : 0));

    // Scenario 2: four generators, period 1, free-flowing output
    for (int i = 0; i < 4; i++) prog(NGEN_LOG'(i), 16'd1, 16'd0, t2_tags[i]);
    gens_en[3:0] = 4'hF;
    gens_used = 8'd3;
    got_tag.delete();
    pulse();
    wait_idle(50, cyc);
    check("t2_cycles", 64'(cyc), 64'd8);
    check("t2_n", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tag.size(); i++)
      check($sformatf("t2_tag%0d", i), {53'd0, got_tag[i]}, {53'd0, t2_tags[i]});

    // Scenario 3: 20-cycle downstream stall holds the first word
    out_a = 1'b0;
    got_tag.delete();
    pulse();
    tick(1);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_v === 1'b1 && out_tag === 11'h010 && out_ct === 9'd1) stable++;
      tick(1);
    end
    check("t3_hold", 64'(stable), 64'd20);
    out_a = 1'b1;
    wait_idle(50, cyc);
    check("t3_n", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tag.size(); i++)
      check($sformatf("t3_tag%0d", i), {53'd0, got_tag[i]}, {53'd0, t2_tags[i]});

    // Scenario 4: two extra pulses during a stall
    out_a = 1'b0;
    got_tag.delete();
    pulse();
    tick(3);
    pulse();
    tick(3);
    check("t4_missed_early", {63'd0, missed_tick}, 64'd0);
    pulse();
    tick(2);
    check("t4_missed_set", {63'd0, missed_tick}, 64'd1);
    check("t4_prog_a_busy", {63'd0, prog_a}, 64'd0);
    out_a = 1'b1;
    wait_idle(200, cyc);
    check("t4_n", 64'(got_tag.size()), 64'd8);
    if (got_tag.size() == 8) check("t4_second_first", {53'd0, got_tag[4]}, 64'h010);
    tick(5);
    check("t4_missed_sticky", {63'd0, missed_tick}, 64'd1);
    check("t4_emitted", {32'd0, emitted_count}, 64'(STATS ? xfer_cnt : 0));

    // Scenario 5: program word held across a stalled sweep
    out_a = 1'b0;
    pulse();
    @(negedge clk);
    prog_gen_idx = 8'd1;
    prog_period  = 16'd2;
    prog_ticks   = 16'd0;
    prog_tag     = 11'h021;
    prog_v       = 1'b1;
    p0 = prog_acc;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (prog_a === 1'b0) stable++;
      tick(1);
    end
    check("t5_prog_a_low", 64'(stable), 64'd10);
    out_a = 1'b1;
    cyc = 0;
    while (!prog_a && cyc < 100) begin
      tick(1);
      cyc++;
    end
    @(negedge clk);
    prog_v = 1'b0;
    check("t5_prog_once", 64'(prog_acc - p0), 64'd1);
    got_tag.delete();
    pulse();
    wait_idle(50, cyc);
    check("t5_a_n", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_tag.size(); i++)
      check($sformatf("t5_a_tag%0d", i), {53'd0, got_tag[i]}, {53'd0, t5_a[i]});
    got_tag.delete();
    pulse();
    wait_idle(50, cyc);
    check("t5_b_n", 64'(got_tag.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_tag.size(); i++)
      check($sformatf("t5_b_tag%0d", i), {53'd0, got_tag[i]}, {53'd0, t5_b[i]});

    // Scenario 6: counter and mid-sweep reset
    do_reset();
    prog(8'd1, 16'd1, 16'd0, 11'h011);
    pulse();
    wait_idle(50, cyc);
    check("t6_n", 64'(got_tag.size()), 64'd4);
    check("t6_emitted", {32'd0, emitted_count}, 64'(STATS ? 4 : 0));
    out_a = 1'b0;
    pulse();
    tick(2);
    check("t6_pre_rst_v", {63'd0, out_v}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_tag.delete();
    check("t6_rst_out_v", {63'd0, out_v}, 64'd0);
    check("t6_rst_out_tag", {53'd0, out_tag}, 64'd0);
    check("t6_rst_emitted", {32'd0, emitted_count}, 64'd0);
    check("t6_rst_idle", {63'd0, prog_a}, 64'd1);
    tick(5);
    out_a = 1'b1;
    tick(3);
    check("t6_no_resume", 64'(got_tag.size()), 64'd0);
    check("t6_out_v_low", {63'd0, out_v}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
